tick_down_timer: RTL and testbench
==================================

// Module: tick_down_timer
// PURPOSE
//  Down-counting interval timer driven by the tick/terminal-count pulse of the
//  prescaler counter (its count_triger/tc output feeds tick_in here).
//  Loads a programmed interval, decrements once per tick and flags expiry.
//  Supports one-shot and auto-reload modes, plus pause, stop and restart.
//  Sits between the prescaler counter and the interrupt/event logic.
// PARAMETERS
//  WIDTH      8   width of interval/count registers
//  ECNT_W     8   width of saturating expiry counter
// PORTS
//  clk         in   1        system clock, rising edge
//  clr         in   1        asynchronous active-low reset
//  tick_in     in   1        1-cycle tick from prescaler counter
//  en          in   1        1 = ticks counted, 0 = paused (state held)
//  start       in   1        1-cycle start/restart request
//  stop        in   1        1-cycle stop request
//  mode_reload in   1        sampled at start: 1 = auto-reload, 0 = one-shot
//  load_val    in   WIDTH    interval in ticks, sampled at start
//  cnt         out  WIDTH    current remaining count
//  busy        out  1        1 while in RUN
//  expire      out  1        1-cycle pulse on expiry
//  expire_cnt  out  ECNT_W   expiries since last start, saturates at all-ones
// BEHAVIOUR
//  Reset (clr=0, async): state=IDLE; cnt=0, busy=0, expire=0, expire_cnt=0,
//   internal reload_reg=0, mode_reg=0. All outputs registered.
//  FSM: IDLE, RUN. busy = (state==RUN).
//  Per-edge priority (highest first): stop, start, tick.
//  IDLE:
//   - start & load_val!=0: cnt<=load_val, reload_reg<=load_val,
//     mode_reg<=mode_reload, expire_cnt<=0, -> RUN. busy high next cycle.
//   - start & load_val==0: expire<=1 for one cycle, expire_cnt<=1, cnt stays 0,
//     remain IDLE (zero interval = immediate expiry, never loops).
//   - tick_in, en, stop ignored.
//  RUN:
//   - stop: cnt<=0, -> IDLE, no expire even if tick/cnt==1 in same cycle.
//   - start (no stop): restart exactly as from IDLE with new load_val/mode;
//     a same-cycle tick is discarded.
//   - tick_in & en & cnt>1: cnt<=cnt-1.
//   - tick_in & en & cnt==1: expire<=1 (next cycle only), expire_cnt+=1
//     (saturating); mode_reg=1: cnt<=reload_reg, stay RUN;
//     mode_reg=0: cnt<=0, -> IDLE.
//   - tick_in & !en: ignored, cnt held (pause). en has no other effect.
//  Latency: expire asserted in the cycle immediately after the tick cycle,
//   coincident with cnt showing 0 (one-shot) or reload value (reload).
//  Interval: exactly load_val ticks from start to expire; reload period
//   exactly reload_reg ticks. Tick in the start cycle not counted.
//  Back-to-back ticks (every cycle) must be handled without loss.
//  load_val/mode_reload changes while RUN have no effect until next start.
//  Reset mid-RUN: immediate return to reset values; expire pulse truncated.
//  expire_cnt: holds at 2^ECNT_W-1, no wrap.
// TESTING
//  1 One-shot: load_val=5, start, tick every 4 clk -> cnt 5,4,3,2,1,0; expire
//    one cycle after 5th tick; busy falls same cycle; expire_cnt=1.
//  2 Reload: load_val=3, mode_reload=1, 9 ticks -> cnt 3,2,1,3,...; 3 expire
//    pulses, busy stays 1, expire_cnt=3; then stop -> cnt=0, busy=0.
//  3 Priority: cnt==1 with tick+stop same cycle -> no expire, cnt=0, IDLE;
//    tick+start in RUN -> cnt=new load_val, tick not counted.
//  4 Pause: load_val=4, 2 ticks, en=0 for 3 ticks, en=1 -> cnt holds at 2,
//    expire after 2 further ticks.
//  5 Edge cases: start with load_val=0 -> single expire, busy stays 0;
//    tick every cycle with load_val=1, reload -> expire every cycle, expire_cnt
//    saturates at 255 after 255+ ticks (ECNT_W=8).
//  6 Reset: clr low mid-RUN (cnt=3) asynchronously between edges -> cnt, busy,
//    expire, expire_cnt all 0 immediately; start after release works normally.

Source files
------------

// File: rtl/tick_down_timer_if.sv
// Bundle of tick/control inputs and count/status outputs of the interval timer.
// Latency: none; plain wires between driver and timer.
// Backpressure: none; the timer is purely reactive to tick/start/stop pulses.
interface tick_down_timer_if #(
  parameter int WIDTH  = 8,
  parameter int ECNT_W = 8
);
  logic              tick_in;
  logic              en;
  logic              start;
  logic              stop;
  logic              mode_reload;
  logic [WIDTH-1:0]  load_val;
  logic [WIDTH-1:0]  cnt;
  logic              busy;
  logic              expire;
  logic [ECNT_W-1:0] expire_cnt;

  // Driver side: prescaler ticks and control pulses in, status out.
  modport master (
    output tick_in, en, start, stop, mode_reload, load_val,
    input  cnt, busy, expire, expire_cnt
  );

  // Timer side.
  modport slave (
    input  tick_in, en, start, stop, mode_reload, load_val,
    output cnt, busy, expire, expire_cnt
  );
endinterface

// File: rtl/tick_down_timer.sv
// Down-counting interval timer: loads an interval, decrements per prescaler tick, flags expiry.
// Latency: expire and the updated cnt appear one cycle after the tick/start edge.
// Backpressure: none; every tick is consumed, including back-to-back ticks each cycle.
module tick_down_timer #(
  parameter int WIDTH  = 8,
  parameter int ECNT_W = 8
) (
  input  logic         clk,
  input  logic         clr,
  tick_down_timer_if.slave tif
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]  reload_q, reload_d;
  logic              mode_q, mode_d;
  logic              expire_q, expire_d;
  logic [ECNT_W-1:0] expire_cnt_q, expire_cnt_d;

  logic              load_zero;
  logic [ECNT_W-1:0] expire_cnt_inc;

  assign load_zero      = (tif.load_val == '0);
  // Saturating increment: all-ones holds rather than wrapping to zero.
  assign expire_cnt_inc = (expire_cnt_q == '1) ? expire_cnt_q : expire_cnt_q + ECNT_W'(1);

  // Next-state logic; priority is stop (only meaningful in RUN), then start, then tick.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    reload_d     = reload_q;
    mode_d       = mode_q;
    expire_d     = 1'b0;
    expire_cnt_d = expire_cnt_q;

    if ((state_q == RUN) && tif.stop) begin
      // Stop wins over a coincident final tick: no expiry is reported.
      cnt_d   = '0;
      state_d = IDLE;
    end else if (tif.start) begin
      // Start/restart; a same-cycle tick is discarded, so the interval is exact.
      if (load_zero) begin
        // Zero interval expires immediately and never enters RUN.
        cnt_d        = '0;
        expire_d     = 1'b1;
        expire_cnt_d = ECNT_W'(1);
        state_d      = IDLE;
      end else begin
        cnt_d        = tif.load_val;
        reload_d     = tif.load_val;
        mode_d       = tif.mode_reload;
        expire_cnt_d = '0;
        state_d      = RUN;
      end
    end else if ((state_q == RUN) && tif.tick_in && tif.en) begin
      if (cnt_q == WIDTH'(1)) begin
        expire_d     = 1'b1;
        expire_cnt_d = expire_cnt_inc;
        if (mode_q) begin
          cnt_d = reload_q;
        end else begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end else begin
        cnt_d = cnt_q - WIDTH'(1);
      end
    end
  end

  // State and datapath registers; reset clears everything including a pending expire pulse.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      reload_q     <= '0;
      mode_q       <= 1'b0;
      expire_q     <= 1'b0;
      expire_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      reload_q     <= reload_d;
      mode_q       <= mode_d;
      expire_q     <= expire_d;
      expire_cnt_q <= expire_cnt_d;
    end
  end

  assign tif.cnt        = cnt_q;
  assign tif.busy       = (state_q == RUN);
  assign tif.expire     = expire_q;
  assign tif.expire_cnt = expire_cnt_q;

endmodule

// File: tb/tb_tick_down_timer.sv
// Self-checking bench for tick_down_timer: directed table, corner sequences, random vs model.
// Latency: outputs checked 1 time unit after each rising edge.
// Backpressure: n/a; stimulus driven on falling edges.
module tb_tick_down_timer;

  localparam int WIDTH  = 8;
  localparam int ECNT_W = 8;
  localparam int ECNT_MAX = (1 << ECNT_W) - 1;

  logic clk;
  logic clr;

  tick_down_timer_if #(.WIDTH(WIDTH), .ECNT_W(ECNT_W)) tif ();

  tick_down_timer #(.WIDTH(WIDTH), .ECNT_W(ECNT_W)) dut (
    .clk (clk),
    .clr (clr),
    .tif (tif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests;
  int fails;

  // Reference model: remaining ticks, period, and counters as plain integers.
  bit m_run;
  int m_left;
  int m_period;
  bit m_auto;
  bit m_exp;
  int m_count;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_left = 0; m_period = 0; m_auto = 0; m_exp = 0; m_count = 0;
  endtask

  task automatic model_edge(input bit st, input bit sp, input bit tk, input bit e,
                            input bit md, input int ld);
    m_exp = 0;
    if (m_run && sp) begin
      m_run = 0;
      m_left = 0;
    end else if (st) begin
      if (ld == 0) begin
        m_run = 0; m_left = 0; m_exp = 1; m_count = 1;
      end else begin
        m_run = 1; m_left = ld; m_period = ld; m_auto = md; m_count = 0;
      end
    end else if (m_run && tk && e) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_exp = 1;
        if (m_count < ECNT_MAX) m_count = m_count + 1;
        if (m_auto) m_left = m_period;
        else m_run = 0;
      end
    end
  endtask

  task automatic compare_model(input string tag);
    check({tag, "_cnt"},    int'(tif.cnt),        m_left);
    check({tag, "_busy"},   int'(tif.busy),       int'(m_run));
    check({tag, "_expire"}, int'(tif.expire),     int'(m_exp));
    check({tag, "_ecnt"},   int'(tif.expire_cnt), m_count);
  endtask

  // One clock: drive on falling edge, model the rising edge, compare shortly after.
  task automatic step(input bit st, input bit sp, input bit tk, input bit e,
                      input bit md, input int ld, input string tag);
    @(negedge clk);
    tif.start = st; tif.stop = sp; tif.tick_in = tk; tif.en = e;
    tif.mode_reload = md; tif.load_val = WIDTH'(ld);
    @(posedge clk);
    model_edge(st, sp, tk, e, md, ld);
    #1;
    compare_model(tag);
  endtask

  typedef struct {
    bit st; bit sp; bit tk; bit e; bit md; int ld;
    int x_cnt; bit x_busy; bit x_exp; int x_ecnt;
  } vec_t;

  vec_t vecs[19];

  initial begin
    tests = 0;
    fails = 0;
    model_reset();
    clr = 1'b0;
    tif.start = 0; tif.stop = 0; tif.tick_in = 0; tif.en = 1;
    tif.mode_reload = 0; tif.load_val = '0;

    //            st sp tk e  md ld   cnt busy exp ecnt
    vecs[0]  = '{1, 0, 0, 1, 0, 5,   5, 1, 0, 0};
    vecs[1]  = '{0, 0, 0, 1, 0, 0,   5, 1, 0, 0};
    vecs[2]  = '{0, 0, 1, 1, 0, 0,   4, 1, 0, 0};
    vecs[3]  = '{0, 0, 1, 1, 0, 0,   3, 1, 0, 0};
    vecs[4]  = '{0, 0, 1, 0, 0, 0,   3, 1, 0, 0};
    vecs[5]  = '{0, 0, 1, 1, 1, 9,   2, 1, 0, 0};
    vecs[6]  = '{0, 0, 1, 1, 0, 0,   1, 1, 0, 0};
    vecs[7]  = '{0, 1, 1, 1, 0, 0,   0, 0, 0, 0};
    vecs[8]  = '{1, 0, 0, 1, 0, 0,   0, 0, 1, 1};
    vecs[9]  = '{0, 0, 0, 1, 0, 0,   0, 0, 0, 1};
    vecs[10] = '{1, 0, 0, 1, 1, 2,   2, 1, 0, 0};
    vecs[11] = '{0, 0, 1, 1, 0, 0,   1, 1, 0, 0};
    vecs[12] = '{0, 0, 1, 1, 0, 0,   2, 1, 1, 1};
    vecs[13] = '{0, 0, 1, 1, 0, 0,   1, 1, 0, 1};
    vecs[14] = '{0, 0, 1, 1, 0, 0,   2, 1, 1, 2};
    vecs[15] = '{1, 0, 1, 1, 0, 7,   7, 1, 0, 0};
    vecs[16] = '{0, 0, 1, 1, 0, 0,   6, 1, 0, 0};
    vecs[17] = '{0, 1, 0, 1, 0, 0,   0, 0, 0, 0};
    vecs[18] = '{0, 0, 1, 1, 0, 0,   0, 0, 0, 0};

    // Reset state
    #12;
    compare_model("reset");
    check("reset_cnt_hw", int'(tif.cnt), 0);
    @(negedge clk);
    clr = 1'b1;

    // Directed table
    for (int i = 0; i < 19; i++) begin
      step(vecs[i].st, vecs[i].sp, vecs[i].tk, vecs[i].e, vecs[i].md, vecs[i].ld, "tbl_model");
      check($sformatf("tbl%0d_cnt", i),  int'(tif.cnt),        vecs[i].x_cnt);
      check($sformatf("tbl%0d_busy", i), int'(tif.busy),       int'(vecs[i].x_busy));
      check($sformatf("tbl%0d_exp", i),  int'(tif.expire),     int'(vecs[i].x_exp));
      check($sformatf("tbl%0d_ecnt", i), int'(tif.expire_cnt), vecs[i].x_ecnt);
    end

    // One-shot, load 5, tick every 4 clocks
    step(1, 0, 0, 1, 0, 5, "os");
    for (int t = 0; t < 5; t++) begin
      for (int k = 0; k < 3; k++) step(0, 0, 0, 1, 0, 0, "os");
      step(0, 0, 1, 1, 0, 0, "os");
    end
    check("os_expire", int'(tif.expire), 1);
    check("os_busy", int'(tif.busy), 0);
    check("os_cnt", int'(tif.cnt), 0);
    check("os_ecnt", int'(tif.expire_cnt), 1);
    step(0, 0, 0, 1, 0, 0, "os");
    check("os_expire_pulse", int'(tif.expire), 0);

    // Reload with load 1 and tick every cycle: saturation of expire_cnt
    step(1, 0, 0, 1, 1, 1, "sat");
    for (int t = 0; t < 300; t++) step(0, 0, 1, 1, 0, 0, "sat");
    check("sat_ecnt", int'(tif.expire_cnt), ECNT_MAX);
    check("sat_expire", int'(tif.expire), 1);
    check("sat_busy", int'(tif.busy), 1);
    step(0, 1, 0, 1, 0, 0, "sat_stop");

    // Asynchronous reset mid-RUN at cnt=3
    step(1, 0, 0, 1, 0, 5, "ar");
    step(0, 0, 1, 1, 0, 0, "ar");
    step(0, 0, 1, 1, 0, 0, "ar");
    check("ar_pre_cnt", int'(tif.cnt), 3);
    #2;
    clr = 1'b0;
    #1;
    model_reset();
    check("ar_cnt", int'(tif.cnt), 0);
    check("ar_busy", int'(tif.busy), 0);
    check("ar_expire", int'(tif.expire), 0);
    check("ar_ecnt", int'(tif.expire_cnt), 0);
    @(negedge clk);
    clr = 1'b1;
    step(1, 0, 0, 1, 0, 2, "ar_post");
    check("ar_post_cnt", int'(tif.cnt), 2);
    step(0, 0, 1, 1, 0, 0, "ar_post");
    step(0, 0, 1, 1, 0, 0, "ar_post");
    check("ar_post_expire", int'(tif.expire), 1);

    // Randomized traffic against the model
    for (int r = 0; r < 3000; r++) begin
      bit st, sp, tk, e, md;
      int ld;
      st = ($urandom_range(0, 19) == 0);
      sp = ($urandom_range(0, 39) == 0);
      tk = ($urandom_range(0, 1) == 1);
      e  = ($urandom_range(0, 4) != 0);
      md = $urandom_range(0, 1);
      ld = $urandom_range(0, 6);
      step(st, sp, tk, e, md, ld, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
